// File: rtl/radix_4_otf_converter.sv
// Radix-4 on-the-fly quotient converter: folds signed digits into Q / QM (Q - 1 ulp).
// Optional one-hot digit checking is enabled by defining RADIX_4_OTF_ONEHOT_CHECK_EN.
module radix_4_otf_converter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [CNT_W-1:0] iter_num_i,
    input  logic             quot_valid_i,
    output logic             quot_ready_o,
    input  logic [4:0]       quot_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qm_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] qm_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] qm_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [4:0]       digit;

`ifdef RADIX_4_OTF_ONEHOT_CHECK_EN
    logic err_reg;
    logic legal;
    assign legal = (quot_i != 5'd0) && ((quot_i & (quot_i - 5'd1)) == 5'd0);
    // An illegal code is folded in as digit 0 so Q/QM stay well defined.
    assign digit = legal ? quot_i : 5'b00100;
    assign err_o = err_reg;
`else
    assign digit = quot_i;
    assign err_o = 1'b0;
`endif

    // Candidate next values indexed by digit bit: 4:+2 3:+1 2:0 1:-1 0:-2.
    logic [WIDTH-1:0] q_cand  [5];
    logic [WIDTH-1:0] qm_cand [5];
    logic [WIDTH-1:0] q_term  [5];
    logic [WIDTH-1:0] qm_term [5];

    assign q_cand[4]  = {q_reg[WIDTH-3:0],  2'b10};
    assign qm_cand[4] = {q_reg[WIDTH-3:0],  2'b01};
    assign q_cand[3]  = {q_reg[WIDTH-3:0],  2'b01};
    assign qm_cand[3] = {q_reg[WIDTH-3:0],  2'b00};
    assign q_cand[2]  = {q_reg[WIDTH-3:0],  2'b00};
    assign qm_cand[2] = {qm_reg[WIDTH-3:0], 2'b11};
    assign q_cand[1]  = {qm_reg[WIDTH-3:0], 2'b11};
    assign qm_cand[1] = {qm_reg[WIDTH-3:0], 2'b10};
    assign q_cand[0]  = {qm_reg[WIDTH-3:0], 2'b10};
    assign qm_cand[0] = {qm_reg[WIDTH-3:0], 2'b01};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_term
            assign q_term[gi]  = {WIDTH{digit[gi]}} & q_cand[gi];
            assign qm_term[gi] = {WIDTH{digit[gi]}} & qm_cand[gi];
        end
    endgenerate

    always_comb begin
        q_next  = '0;
        qm_next = '0;
        for (int i = 0; i < 5; i++) begin
            q_next  = q_next  | q_term[i];
            qm_next = qm_next | qm_term[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            qm_reg    <= '0;
            cnt_reg   <= '0;
`ifdef RADIX_4_OTF_ONEHOT_CHECK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid_i) begin
                        q_reg     <= '0;
                        qm_reg    <= '1;
                        cnt_reg   <= iter_num_i;
`ifdef RADIX_4_OTF_ONEHOT_CHECK_EN
                        err_reg   <= 1'b0;
`endif
                        state_reg <= (iter_num_i == '0) ? DONE : ITER;
                    end
                end
                ITER: begin
                    if (quot_valid_i) begin
                        q_reg   <= q_next;
                        qm_reg  <= qm_next;
                        cnt_reg <= cnt_reg - CNT_W'(1);
`ifdef RADIX_4_OTF_ONEHOT_CHECK_EN
                        if (!legal) err_reg <= 1'b1;
`endif
                        if (cnt_reg == CNT_W'(1)) state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready_i) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign start_ready_o = (state_reg == IDLE);
    assign quot_ready_o  = (state_reg == ITER);
    assign res_valid_o   = (state_reg == DONE);
    assign q_o           = q_reg;
    assign qm_o          = qm_reg;

endmodule
